// File: rtl/sbox_share_scheduler_if.sv
// Bundle of signals between requesters, the randomness source, the shared
// masked S-box and the scheduler.
//
// Handshake: a request transfers on a cycle where req_valid[i] and
// req_ready[i] are both high, and a random word transfers where rnd_valid and
// rnd_ready are both high. A requester holds req_valid and its shares stable
// until it is accepted. rsp_valid is a one-cycle strobe with no backpressure.
`timescale 1ns/1ps
interface sbox_share_scheduler_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [8*NREQ-1:0] req_in0;
   logic [8*NREQ-1:0] req_in1;
   logic              rnd_valid;
   logic [27:0]       rnd;
   logic              rnd_ready;
   logic [7:0]        sbox_in0;
   logic [7:0]        sbox_in1;
   logic [27:0]       sbox_r;
   logic [7:0]        sbox_out0;
   logic [7:0]        sbox_out1;
   logic [NREQ-1:0]   rsp_valid;
   logic [7:0]        rsp_out0;
   logic [7:0]        rsp_out1;

   // Scheduler side
   modport slave (
      input  req_valid, req_in0, req_in1, rnd_valid, rnd, sbox_out0, sbox_out1,
      output req_ready, rnd_ready, sbox_in0, sbox_in1, sbox_r,
             rsp_valid, rsp_out0, rsp_out1
   );

   // Environment side: requesters, randomness source and S-box
   modport master (
      output req_valid, req_in0, req_in1, rnd_valid, rnd, sbox_out0, sbox_out1,
      input  req_ready, rnd_ready, sbox_in0, sbox_in1, sbox_r,
             rsp_valid, rsp_out0, rsp_out1
   );
endinterface

// File: rtl/sbox_share_scheduler.sv
// Round-robin scheduler sharing one pipelined two-share masked S-box among
// NREQ requesters. One byte issues per cycle when a request and a fresh
// random word are both present; the owner tag rides a LAT-deep shift register
// alongside the S-box pipeline so the result returns to the right requester.
`timescale 1ns/1ps
module sbox_share_scheduler #(
   parameter int NREQ = 4,
   parameter int LAT  = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   sbox_share_scheduler_if.slave bus,
   output logic                  busy,
   output logic [15:0]           stall_cnt
);
   localparam int TAGW = $clog2(NREQ);

   logic [TAGW-1:0] ptr_q, ptr_d;
   logic [TAGW-1:0] grant;
   logic [TAGW-1:0] cand;
   logic            grant_found;
   logic            issue;
   logic [LAT-1:0]  v_q;
   logic [TAGW-1:0] tag_q [LAT];
   logic [15:0]     stall_cnt_q, stall_cnt_d;

   // First requesting index found scanning upward from the round-robin pointer
   always_comb begin
      grant_found = 1'b0;
      grant       = '0;
      cand        = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = TAGW'((int'(ptr_q) + k) % NREQ);
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant       = cand;
         end
      end
   end

   // A random word is never reused, so nothing issues without one
   assign issue = grant_found & bus.rnd_valid;

   // Issue side: only the granted requester's shares reach the S-box, else zeros
   always_comb begin
      bus.req_ready = '0;
      bus.rnd_ready = issue;
      bus.sbox_in0  = '0;
      bus.sbox_in1  = '0;
      bus.sbox_r    = '0;
      if (issue) begin
         bus.req_ready[grant] = 1'b1;
         bus.sbox_in0         = bus.req_in0[{grant, 3'b000} +: 8];
         bus.sbox_in1         = bus.req_in1[{grant, 3'b000} +: 8];
         bus.sbox_r           = bus.rnd;
      end
   end

   // Response side: route S-box output to the owner of the oldest tracked byte
   always_comb begin
      bus.rsp_valid = '0;
      bus.rsp_out0  = '0;
      bus.rsp_out1  = '0;
      if (v_q[LAT-1]) begin
         bus.rsp_valid[tag_q[LAT-1]] = 1'b1;
         bus.rsp_out0                = bus.sbox_out0;
         bus.rsp_out1                = bus.sbox_out1;
      end
   end

   // Next pointer and saturating starvation counter
   always_comb begin
      ptr_d       = ptr_q;
      stall_cnt_d = stall_cnt_q;
      if (issue) begin
         ptr_d = (grant == TAGW'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
      if ((|bus.req_valid) && !bus.rnd_valid && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Control state; reset drops every in-flight byte
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q       <= '0;
         v_q         <= '0;
         stall_cnt_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         stall_cnt_q <= stall_cnt_d;
         v_q[0]      <= issue;
         for (int k = 1; k < LAT; k++) begin
            v_q[k] <= v_q[k-1];
         end
      end
   end

   // Owner tags are qualified by v_q, so they need no reset
   always_ff @(posedge CLK) begin
      tag_q[0] <= grant;
      for (int k = 1; k < LAT; k++) begin
         tag_q[k] <= tag_q[k-1];
      end
   end

   assign busy      = (|bus.req_valid) | (|v_q);
   assign stall_cnt = stall_cnt_q;
endmodule
